// File: rtl/universal_shift_register.sv
// WIDTH-bit register with synchronous reset, clock enable and a mode-selected
// next state: hold, serial shift, parallel load, rotate, up/down count with wrap flag.
module universal_shift_register #(
  parameter int          WIDTH       = 8,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [2:0]       i_mode,
  input  logic             i_ser_in,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_ser_out_r,
  output logic             o_ser_out_l,
  output logic             o_carry,
  output logic             o_zero
);

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SHR  = 3'b001,
    M_SHL  = 3'b010,
    M_LOAD = 3'b011,
    M_ROR  = 3'b100,
    M_ROL  = 3'b101,
    M_UP   = 3'b110,
    M_DOWN = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] RST_V = RESET_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;
  logic             r_carry;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_carry_nxt;
  mode_e            w_mode;

  assign w_mode = mode_e'(i_mode);

  // Carry is only ever set by a wrap; every other enabled op clears it.
  always_comb begin
    w_q_nxt     = r_q;
    w_carry_nxt = 1'b0;
    unique case (w_mode)
      M_HOLD: w_q_nxt = r_q;
      M_SHR:  w_q_nxt = {i_ser_in, r_q[WIDTH-1:1]};
      M_SHL:  w_q_nxt = {r_q[WIDTH-2:0], i_ser_in};
      M_LOAD: w_q_nxt = i_d;
      M_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
      M_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      M_UP: begin
        w_q_nxt     = r_q + ONE;
        w_carry_nxt = &r_q;
      end
      M_DOWN: begin
        w_q_nxt     = r_q - ONE;
        w_carry_nxt = ~|r_q;
      end
      default: w_q_nxt = r_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q     <= RST_V;
      r_carry <= 1'b0;
    end else if (i_en) begin
      r_q     <= w_q_nxt;
      r_carry <= w_carry_nxt;
    end
  end

  assign o_q         = r_q;
  assign o_carry     = r_carry;
  assign o_ser_out_r = r_q[0];
  assign o_ser_out_l = r_q[WIDTH-1];
  assign o_zero      = (r_q == '0);

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed walk-through of the register's modes followed by randomized traffic,
// all checked against an arithmetic reference model.
module tb_universal_shift_register;
  localparam int W    = 4;
  localparam int RV   = 'hA;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst, en, ser;
  logic [2:0]   mode;
  logic [W-1:0] d;
  logic [W-1:0] q;
  logic         sr, sl, carry, zero;

  int vectors = 0;
  int errors  = 0;
  int mq, mc;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(W), .RESET_VALUE(RV)) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_ser_in(ser), .i_d(d),
    .o_q(q), .o_ser_out_r(sr), .o_ser_out_l(sl), .o_carry(carry), .o_zero(zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one edge, advance the model, compare every output against it.
  task automatic step(input logic r, input logic e, input int m, input logic s, input int dv);
    int nq, nc;
    rst = r; en = e; mode = 3'(m); ser = s; d = W'(dv);
    nq = mq; nc = mc;
    if (r) begin
      nq = RV & MASK; nc = 0;
    end else if (e) begin
      nc = 0;
      case (m)
        1: nq = (mq >> 1) | (int'(s) << (W-1));
        2: nq = ((mq << 1) | int'(s)) & MASK;
        3: nq = dv & MASK;
        4: nq = (mq >> 1) | ((mq & 1) << (W-1));
        5: nq = ((mq << 1) & MASK) | (mq >> (W-1));
        6: begin nq = (mq + 1) % (1 << W); nc = (mq == MASK); end
        7: begin nq = (mq + MASK) % (1 << W); nc = (mq == 0); end
        default: nq = mq;
      endcase
    end
    mq = nq; mc = nc;
    @(posedge clk); #1;
    chk("q",     32'(q),     32'(mq));
    chk("carry", 32'(carry), 32'(mc));
    chk("zero",  32'(zero),  32'(mq == 0));
    chk("serR",  32'(sr),    32'(mq & 1));
    chk("serL",  32'(sl),    32'((mq >> (W-1)) & 1));
  endtask

  task automatic expect_qc(input string tag, input int eq, input int ec);
    chk(tag, 32'(q), 32'(eq));
    chk(tag, 32'(carry), 32'(ec));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 3'd0; ser = 1'b0; d = '0;
    mq = 0; mc = 0;

    step(1, 1, 3, 0, 5); step(1, 1, 3, 0, 5);
    expect_qc("rst", 'hA, 0); chk("rst_zero", 32'(zero), 0);
    step(1, 0, 0, 0, 0);
    expect_qc("rst_en0", 'hA, 0);

    step(0, 1, 3, 0, 'b1001);
    step(0, 1, 1, 1, 0); expect_qc("shr1", 'b1100, 0);
    step(0, 1, 1, 0, 0); expect_qc("shr2", 'b0110, 0);
    step(0, 1, 1, 1, 0); expect_qc("shr3", 'b1011, 0);
    step(0, 1, 1, 1, 0); expect_qc("shr4", 'b1101, 0);
    step(0, 1, 2, 0, 0); expect_qc("shl",  'b1010, 0);
    chk("shl_serL", 32'(sl), 1); chk("shl_serR", 32'(sr), 0);

    step(0, 1, 3, 0, 'b0001);
    step(0, 1, 5, 0, 0); expect_qc("rol1", 'b0010, 0);
    step(0, 1, 5, 0, 0); expect_qc("rol2", 'b0100, 0);
    step(0, 1, 5, 0, 0); expect_qc("rol3", 'b1000, 0);
    step(0, 1, 5, 0, 0); expect_qc("rol4", 'b0001, 0);
    step(0, 1, 4, 0, 0); expect_qc("ror",  'b1000, 0);

    step(0, 1, 3, 0, 'hE);
    step(0, 1, 6, 0, 0); expect_qc("up1", 'hF, 0); chk("up1_zero", 32'(zero), 0);
    step(0, 1, 6, 0, 0); expect_qc("up2", 'h0, 1); chk("up2_zero", 32'(zero), 1);
    step(0, 1, 6, 0, 0); expect_qc("up3", 'h1, 0); chk("up3_zero", 32'(zero), 0);
    step(0, 1, 3, 0, 'h1);
    step(0, 1, 7, 0, 0); expect_qc("dn1", 'h0, 0);
    step(0, 1, 7, 0, 0); expect_qc("dn2", 'hF, 1);

    step(0, 1, 3, 0, 'hE);
    step(0, 1, 6, 0, 0);
    step(0, 1, 6, 0, 0); expect_qc("en_wrap", 'h0, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 6, 0, 0); expect_qc("en_hold", 'h0, 1);
    end
    step(0, 1, 6, 0, 0); expect_qc("en_resume", 'h1, 0);

    step(0, 1, 3, 0, 'h3);
    step(0, 1, 6, 0, 0); expect_qc("mid_up", 'h4, 0);
    step(1, 1, 6, 0, 0); expect_qc("mid_rst", 'hA, 0);
    step(0, 1, 6, 0, 0); expect_qc("mid_resume", 'hB, 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(15) == 0), ($urandom_range(3) != 0),
           int'($urandom_range(7)), 1'($urandom_range(1)), int'($urandom_range(MASK)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's single-bit master-slave D flip-flop. It is a WIDTH-bit edge-triggered register with synchronous reset and clock enable. A mode-selected next-state function provides hold, serial shift, parallel load, rotate, and up/down count. It is the general-purpose storage/shift element for the upcoming serial-link and counter labs, and replaces ad hoc chains of single-bit flip-flops.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
RESET_VALUE, 0, value loaded into Q on reset (WIDTH bits, upper bits truncated).

Ports:
Clk  input  1  clock; all state updates on rising edge.
Rst  input  1  synchronous, active-high reset.
En  input  1  clock enable; 0 = hold everything.
Mode  input  3  operation select (encoding below).
SerIn  input  1  serial input bit for shift modes.
D  input  WIDTH  parallel load data.
Q  output  WIDTH  register contents.
SerOutR  output  1  Q[0], combinational from Q.
SerOutL  output  1  Q[WIDTH-1], combinational from Q.
Carry  output  1  registered wrap flag for count modes.
Zero  output  1  1 when Q == 0, combinational from Q.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: Clk with Rst, polarity and synchronicity fixed.
- Priority at each rising Clk edge: Rst > En > Mode.
- Rst=1: Q <= RESET_VALUE and Carry <= 0, regardless of En and Mode.
- Rst=0, En=0: Q and Carry hold.
- Rst=0, En=1, Mode encoding:
  - 000 hold: Q unchanged; Carry <= 0.
  - 001 shift right: Q <= {SerIn, Q[W-1:1]}; Carry <= 0.
  - 010 shift left: Q <= {Q[W-2:0], SerIn}; Carry <= 0.
  - 011 load: Q <= D; Carry <= 0.
  - 100 rotate right: Q <= {Q[0], Q[W-1:1]}; Carry <= 0.
  - 101 rotate left: Q <= {Q[W-2:0], Q[W-1]}; Carry <= 0.
  - 110 count up: Q <= Q+1 mod 2^W; Carry <= 1 iff old Q was all ones.
  - 111 count down: Q <= Q-1 mod 2^W; Carry <= 1 iff old Q was 0.
- Latency: one cycle from an enabled edge to the new Q and Carry. SerOutR, SerOutL and Zero follow Q with no added cycle.
- Carry is a one-cycle pulse per wrap event. It is cleared by any other enabled operation and holds while En=0.
- Mode changes take effect at the next enabled edge. No internal state exists besides Q and Carry; the block has no FSM beyond the mode decode.
- Rst asserted mid-count or mid-shift aborts the operation at that edge. Operation resumes from RESET_VALUE on the first edge with Rst=0.
- Before the first reset, Q is X. The bench must reset before checking outputs.
- Arithmetic is unsigned and width-exact. There is no saturation.

Test Plan:
- Reset (WIDTH=4, RESET_VALUE=4'hA): Rst=1 for 2 edges with En=1, Mode=011, D=4'h5 -> Q=4'hA, Carry=0, Zero=0. Rst held with En=0 -> same result.
- Load and shift: load 4'b1001, then Mode=001 with SerIn=1,0,1,1 over 4 edges -> Q=1100, 0110, 1011, 1101. Mode=010 with SerIn=0 -> Q=1010; SerOutL=1, SerOutR=0.
- Rotate: load 4'b0001, Mode=101 for 4 edges -> Q=0010, 0100, 1000, 0001. Mode=100 once -> Q=1000.
- Count wrap: load 4'hE, Mode=110 for 3 edges -> Q=F, 0, 1 with Carry=0, 1, 0. Zero=1 only in the Q=0 cycle. Load 4'h1, Mode=111 for 2 edges -> Q=0, F with Carry=0, 1.
- Enable gating: during count up, drop En for 3 edges -> Q and Carry frozen (including Carry=1 held). Raise En -> count resumes from the frozen value.
- Reset mid-operation: count up from 4'h3, assert Rst on the 2nd edge -> Q=4'hA, Carry=0 at that edge. Deassert Rst -> next edge Q=4'hB.
